// File: rtl/acc_wb_arbiter.sv
// acc_wb_arbiter
// Collects final convolution results from N_COL accumulator columns and
// serializes them onto a single valid/ready write port toward the ofmap SRAM.
// Each column owns a small FIFO. A round-robin arbiter drains the FIFOs into
// one output register. Layer completion is reported once every column's
// last-flagged result has been accepted by the writer.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   layer_start_i     pulse: clears overflow and per-column done bits
//   conv_valid_i      per-column result strobe (no backpressure)
//   conv_last_i       per-column "final result of layer" flag
//   conv_result_i     per-column result data, column c at [c*DATA_W +: DATA_W]
//   addr_i            per-column result index, column c at [c*ADDR_W +: ADDR_W]
//   wr_en_o           write request valid
//   wr_addr_o         {column index, addr}
//   wr_data_o         write data
//   wr_ready_i        writer accepts when wr_en_o & wr_ready_i
//   done_o            one-cycle pulse when all columns' last results are written
//   overflow_o        sticky: a result was dropped on a full FIFO
//   busy_o            any FIFO non-empty or output register occupied
module acc_wb_arbiter #(
   parameter int N_COL      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              layer_start_i,
   input  logic [N_COL-1:0]                  conv_valid_i,
   input  logic [N_COL-1:0]                  conv_last_i,
   input  logic [N_COL*DATA_W-1:0]           conv_result_i,
   input  logic [N_COL*ADDR_W-1:0]           addr_i,
   output logic                              wr_en_o,
   output logic [$clog2(N_COL)+ADDR_W-1:0]   wr_addr_o,
   output logic [DATA_W-1:0]                 wr_data_o,
   input  logic                              wr_ready_i,
   output logic                              done_o,
   output logic                              overflow_o,
   output logic                              busy_o
);

   localparam int COL_W = $clog2(N_COL);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 1 + DATA_W + ADDR_W;   // {last, data, addr}

   logic [ENT_W-1:0] mem_r    [N_COL][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r [N_COL];
   logic [PTR_W-1:0] rd_ptr_r [N_COL];
   logic [CNT_W-1:0] count_r  [N_COL];

   logic [N_COL-1:0] nonempty_s;
   logic [N_COL-1:0] full_s;
   logic [N_COL-1:0] push_s;
   logic [N_COL-1:0] pop_s;
   logic [N_COL-1:0] drop_s;

   logic [COL_W-1:0] rr_ptr_r;
   logic [COL_W-1:0] grant_s;
   logic             grant_valid_s;
   logic             free_s;
   logic             load_s;
   logic [ENT_W-1:0] head_s;
   logic             out_last_r;
   logic             accept_s;
   logic [N_COL-1:0] done_bits_r;
   logic [N_COL-1:0] done_next_s;

   // FIFO occupancy flags
   always_comb begin
      nonempty_s = {N_COL{1'b0}};
      full_s     = {N_COL{1'b0}};
      for (int c = 0; c < N_COL; c++) begin
         nonempty_s[c] = (count_r[c] != {CNT_W{1'b0}});
         full_s[c]     = (count_r[c] == CNT_W'(FIFO_DEPTH));
      end
   end

   // Round-robin search: first non-empty column at or above rr_ptr_r, wrapping
   always_comb begin : grant_search
      logic [COL_W-1:0] cand;
      grant_valid_s = 1'b0;
      grant_s       = {COL_W{1'b0}};
      cand          = {COL_W{1'b0}};
      for (int i = 0; i < N_COL; i++) begin
         cand = rr_ptr_r + COL_W'(i);
         if (!grant_valid_s && nonempty_s[cand]) begin
            grant_valid_s = 1'b1;
            grant_s       = cand;
         end else begin
            grant_s       = grant_s;
         end
      end
   end

   // Output register is free when empty or being accepted this cycle
   always_comb begin
      accept_s = wr_en_o & wr_ready_i;
      free_s   = ~wr_en_o | wr_ready_i;
      load_s   = free_s & grant_valid_s;
      head_s   = mem_r[grant_s][rd_ptr_r[grant_s]];
   end

   // Per-column push/pop/drop; a full FIFO popped this cycle still takes the push
   always_comb begin
      pop_s  = {N_COL{1'b0}};
      push_s = {N_COL{1'b0}};
      drop_s = {N_COL{1'b0}};
      for (int c = 0; c < N_COL; c++) begin
         pop_s[c]  = load_s && (grant_s == COL_W'(c));
         push_s[c] = conv_valid_i[c] && (!full_s[c] || pop_s[c]);
         drop_s[c] = conv_valid_i[c] && full_s[c] && !pop_s[c];
      end
   end

   // FIFO storage; contents need no reset because occupancy is tracked separately
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_COL; c++) begin
         if (push_s[c]) begin
            mem_r[c][wr_ptr_r[c]] <= {conv_last_i[c],
                                      conv_result_i[c*DATA_W +: DATA_W],
                                      addr_i[c*ADDR_W +: ADDR_W]};
         end
      end
   end

   // FIFO pointers and occupancy counters
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_COL; c++) begin
         if (!rst_n) begin
            wr_ptr_r[c] <= {PTR_W{1'b0}};
            rd_ptr_r[c] <= {PTR_W{1'b0}};
            count_r[c]  <= {CNT_W{1'b0}};
         end else begin
            if (push_s[c]) wr_ptr_r[c] <= wr_ptr_r[c] + PTR_W'(1);
            if (pop_s[c])  rd_ptr_r[c] <= rd_ptr_r[c] + PTR_W'(1);
            case ({push_s[c], pop_s[c]})
               2'b10:   count_r[c] <= count_r[c] + CNT_W'(1);
               2'b01:   count_r[c] <= count_r[c] - CNT_W'(1);
               default: count_r[c] <= count_r[c];
            endcase
         end
      end
   end

   // Output register and round-robin pointer; held stable while stalled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en_o    <= 1'b0;
         wr_addr_o  <= {(COL_W+ADDR_W){1'b0}};
         wr_data_o  <= {DATA_W{1'b0}};
         out_last_r <= 1'b0;
         rr_ptr_r   <= {COL_W{1'b0}};
      end else if (load_s) begin
         wr_en_o    <= 1'b1;
         wr_addr_o  <= {grant_s, head_s[ADDR_W-1:0]};
         wr_data_o  <= head_s[ADDR_W +: DATA_W];
         out_last_r <= head_s[ENT_W-1];
         rr_ptr_r   <= grant_s + COL_W'(1);
      end else if (free_s) begin
         wr_en_o    <= 1'b0;
      end
   end

   // Done bits including any last accepted this cycle
   always_comb begin
      done_next_s = done_bits_r;
      if (accept_s && out_last_r) begin
         done_next_s[wr_addr_o[ADDR_W +: COL_W]] = 1'b1;
      end else begin
         done_next_s = done_bits_r;
      end
   end

   // Completion tracking; layer_start_i overrides a coincident last acceptance
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_bits_r <= {N_COL{1'b0}};
         done_o      <= 1'b0;
      end else if (layer_start_i) begin
         done_bits_r <= {N_COL{1'b0}};
         done_o      <= 1'b0;
      end else if (&done_next_s) begin
         done_bits_r <= {N_COL{1'b0}};
         done_o      <= 1'b1;
      end else begin
         done_bits_r <= done_next_s;
         done_o      <= 1'b0;
      end
   end

   // Sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_o <= 1'b0;
      end else if (layer_start_i) begin
         overflow_o <= 1'b0;
      end else if (|drop_s) begin
         overflow_o <= 1'b1;
      end else begin
         overflow_o <= overflow_o;
      end
   end

   assign busy_o = (|nonempty_s) | wr_en_o;

endmodule
